// File: rtl/glb_cfg_ring_master.sv
// Initiator of the GLB tile config ring: turns single host register requests into ring strobes.
// Optional read timeout is enabled by defining GLB_CFG_MASTER_TIMEOUT_EN.
module glb_cfg_ring_master #(
    parameter int unsigned AXI_DATA_WIDTH      = 32,
    parameter int unsigned AXI_BYTE_OFFSET     = 2,
    parameter int unsigned REG_ADDR_WIDTH      = 6,
    parameter int unsigned TILE_SEL_ADDR_WIDTH = 4,
    parameter int unsigned NUM_GLB_TILES       = 16,
    parameter int unsigned CFG_ADDR_WIDTH      = AXI_BYTE_OFFSET + REG_ADDR_WIDTH +
                                                 TILE_SEL_ADDR_WIDTH,
    parameter int unsigned RD_TIMEOUT          = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    // Host request
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [CFG_ADDR_WIDTH-1:0] req_addr,
    input  logic [AXI_DATA_WIDTH-1:0] req_wdata,
    // Host response
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    // Ring, west port of tile 0
    output logic                      cfg_wr_en,
    output logic [CFG_ADDR_WIDTH-1:0] cfg_wr_addr,
    output logic [AXI_DATA_WIDTH-1:0] cfg_wr_data,
    output logic                      cfg_rd_en,
    output logic [CFG_ADDR_WIDTH-1:0] cfg_rd_addr,
    output logic                      cfg_wr_clk_en,
    output logic                      cfg_rd_clk_en,
    input  logic [AXI_DATA_WIDTH-1:0] cfg_rd_data,
    input  logic                      cfg_rd_data_valid
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRdWait,
        StRsp
    } state_e;

    state_e state;
    logic   write_q;

    logic [TILE_SEL_ADDR_WIDTH-1:0] req_tile;
    logic                           req_legal;

    assign cfg_wr_clk_en = 1'b1;
    assign cfg_rd_clk_en = 1'b1;

    always_comb begin
        req_tile  = req_addr[AXI_BYTE_OFFSET+REG_ADDR_WIDTH +: TILE_SEL_ADDR_WIDTH];
        req_legal = (32'(req_tile) < NUM_GLB_TILES) &&
                    (req_addr[AXI_BYTE_OFFSET-1:0] == '0);
    end

`ifdef GLB_CFG_MASTER_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(RD_TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(RD_TIMEOUT);

    logic [CNT_WIDTH-1:0] rd_cnt;
`else
    // Without the timeout a hung read is only cleared by reset.
    logic unused_rd_timeout;
    assign unused_rd_timeout = ^RD_TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            write_q     <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            cfg_wr_en   <= 1'b0;
            cfg_wr_addr <= '0;
            cfg_wr_data <= '0;
            cfg_rd_en   <= 1'b0;
            cfg_rd_addr <= '0;
`ifdef GLB_CFG_MASTER_TIMEOUT_EN
            rd_cnt      <= '0;
`endif
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        if (req_legal) begin
                            // Strobes are registered here so they are high during StIssue.
                            state <= StIssue;
                            if (req_write) begin
                                cfg_wr_en   <= 1'b1;
                                cfg_wr_addr <= req_addr;
                                cfg_wr_data <= req_wdata;
                            end else begin
                                cfg_rd_en   <= 1'b1;
                                cfg_rd_addr <= req_addr;
                            end
                        end else begin
                            state     <= StRsp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end

                StIssue: begin
                    cfg_wr_en   <= 1'b0;
                    cfg_wr_addr <= '0;
                    cfg_wr_data <= '0;
                    cfg_rd_en   <= 1'b0;
                    cfg_rd_addr <= '0;
                    if (write_q) begin
                        state     <= StRsp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        state  <= StRdWait;
`ifdef GLB_CFG_MASTER_TIMEOUT_EN
                        rd_cnt <= '0;
`endif
                    end
                end

                StRdWait: begin
                    if (cfg_rd_data_valid) begin
                        state     <= StRsp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= cfg_rd_data;
                    end
`ifdef GLB_CFG_MASTER_TIMEOUT_EN
                    else if (rd_cnt == CNT_MAX) begin
                        state     <= StRsp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
`endif
                end

                StRsp: begin
                    if (rsp_ready) begin
                        state     <= StIdle;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule
